// File: rtl/fetch_decode_memory.sv
// Instruction-side front end: byte-addressed unified memory with a burst-capable
// loader port, a fetch stage that streams words from START_ADDR, and a decode
// stage that registers the MIPS instruction fields.
module fetch_decode_memory #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DEPTH         = 1048576,
  parameter logic [31:0] START_ADDR    = 32'h80020000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [1:0]               access_size,
  input  logic                     rw,
  input  logic                     enable,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     enable_fetch,
  input  logic                     stall,
  input  logic                     enable_decode,
  output logic [ADDRESS_WIDTH-1:0] pc_fetch,
  output logic                     rw_fetch,
  output logic [31:0]              access_size_fetch,
  output logic [ADDRESS_WIDTH-1:0] pc_decode,
  output logic [31:0]              insn,
  output logic [5:0]               opcode_out,
  output logic [4:0]               rs_out,
  output logic [4:0]               rt_out,
  output logic [4:0]               rd_out,
  output logic [4:0]               sa_out,
  output logic [5:0]               func_out,
  output logic [25:0]              imm_out,
  output logic                     decode_valid
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [7:0]               mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_rw;
  logic                     mem_en;
  logic [1:0]               mem_size;
  logic [ADDRESS_WIDTH-1:0] burst_addr;
  logic                     burst_rw;
  logic [3:0]               burst_cnt;
  logic                     loader_go;
  logic                     burst_go;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic                     acc_rw;
  logic                     write_now;
  logic [IDX_W-1:0]         idx0, idx1, idx2, idx3;
  logic [31:0]              rd_word;
  logic                     fd_valid;
  logic                     is_jump;

  assign rw_fetch          = 1'b1;
  assign access_size_fetch = '0;

  // Memory port mux: fetch owns the port whenever it is enabled
  always_comb begin
    mem_addr = address;
    mem_rw   = rw;
    mem_en   = enable;
    mem_size = access_size;
    if (enable_fetch) begin
      mem_addr = pc_fetch;
      mem_rw   = 1'b1;
      mem_en   = 1'b1;
      mem_size = 2'b00;
    end
  end

  // Access address selection and big-endian word assembly (index wraps mod DEPTH)
  always_comb begin
    loader_go = !enable_fetch && mem_en && !busy;
    burst_go  = !enable_fetch && busy;
    acc_addr  = burst_go ? burst_addr : mem_addr;
    acc_rw    = burst_go ? burst_rw : mem_rw;
    write_now = (loader_go || burst_go) && !acc_rw;
    idx0      = IDX_W'(acc_addr) - IDX_W'(START_ADDR);
    idx1      = idx0 + IDX_W'(1);
    idx2      = idx0 + IDX_W'(2);
    idx3      = idx0 + IDX_W'(3);
    rd_word   = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
  end

  // Memory array write; contents survive reset
  always_ff @(posedge clock) begin
    if (write_now && !reset) begin
      mem[idx0] <= data_in[31:24];
      mem[idx1] <= data_in[23:16];
      mem[idx2] <= data_in[15:8];
      mem[idx3] <= data_in[7:0];
    end
  end

  // Read data register and burst down-counter; busy clears at terminal count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      burst_cnt  <= '0;
      burst_addr <= '0;
      burst_rw   <= 1'b0;
      data_out   <= '0;
    end else if (enable_fetch) begin
      busy     <= 1'b0;
      data_out <= rd_word;
    end else if (loader_go) begin
      if (mem_rw) data_out <= rd_word;
      burst_addr <= mem_addr + ADDRESS_WIDTH'(4);
      burst_rw   <= mem_rw;
      busy       <= (mem_size != 2'b00);
      case (mem_size)
        2'b00:   burst_cnt <= 4'd0;
        2'b01:   burst_cnt <= 4'd3;
        2'b10:   burst_cnt <= 4'd7;
        default: burst_cnt <= 4'd15;
      endcase
    end else if (busy) begin
      if (burst_rw) data_out <= rd_word;
      burst_addr <= burst_addr + ADDRESS_WIDTH'(4);
      burst_cnt  <= burst_cnt - 4'd1;
      if (burst_cnt == 4'd1) busy <= 1'b0;
    end
  end

  // Program counter and fetch/decode register; PC parks at START_ADDR while fetch is off
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_fetch  <= START_ADDR;
      pc_decode <= '0;
      insn      <= '0;
      fd_valid  <= 1'b0;
    end else if (!enable_fetch) begin
      pc_fetch <= START_ADDR;
      fd_valid <= 1'b0;
    end else if (!stall) begin
      pc_fetch  <= pc_fetch + ADDRESS_WIDTH'(4);
      pc_decode <= pc_fetch;
      insn      <= rd_word;
      fd_valid  <= 1'b1;
    end
  end

  assign is_jump = (insn[31:27] == 5'b00001);

  // Decode register: field split, J/JAL take the 26-bit target, others sign-extend imm16
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode_out   <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
      sa_out       <= '0;
      func_out     <= '0;
      imm_out      <= '0;
      decode_valid <= 1'b0;
    end else begin
      decode_valid <= enable_decode && enable_fetch && fd_valid;
      if (enable_decode) begin
        opcode_out <= insn[31:26];
        rs_out     <= insn[25:21];
        rt_out     <= insn[20:16];
        rd_out     <= insn[15:11];
        sa_out     <= insn[10:6];
        func_out   <= insn[5:0];
        imm_out    <= is_jump ? insn[25:0] : {{10{insn[15]}}, insn[15:0]};
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_memory.sv
// Directed bench for fetch_decode_memory: loader writes/bursts, fetch stream
// with a stall window, address wrap, byte order and reset abort.
module tb_fetch_decode_memory;

  localparam logic [31:0] START = 32'h80020000;
  localparam int          DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        enable_fetch;
  logic        stall;
  logic        enable_decode;
  logic [31:0] pc_fetch;
  logic        rw_fetch;
  logic [31:0] access_size_fetch;
  logic [31:0] pc_decode;
  logic [31:0] insn;
  logic [5:0]  opcode_out;
  logic [4:0]  rs_out, rt_out, rd_out, sa_out;
  logic [5:0]  func_out;
  logic [25:0] imm_out;
  logic        decode_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog [12];
  logic [31:0] bw [4];

  logic [31:0] exp_pc, exp_pcd, exp_insn, exp_fld;
  logic        exp_fdv, exp_dv;

  fetch_decode_memory dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .access_size(access_size), .rw(rw), .enable(enable), .busy(busy),
    .data_out(data_out), .enable_fetch(enable_fetch), .stall(stall),
    .enable_decode(enable_decode), .pc_fetch(pc_fetch), .rw_fetch(rw_fetch),
    .access_size_fetch(access_size_fetch), .pc_decode(pc_decode), .insn(insn),
    .opcode_out(opcode_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .sa_out(sa_out), .func_out(func_out), .imm_out(imm_out),
    .decode_valid(decode_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    address = a; data_in = d; rw = 1'b0; access_size = 2'b00; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
  endtask

  task automatic mem_read(input logic [31:0] a);
    address = a; rw = 1'b1; access_size = 2'b00; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
  endtask

  initial begin
    prog[0]  = 32'h27BDFFF8; prog[1]  = 32'h00851020; prog[2]  = 32'h0C008010;
    prog[3]  = 32'h8C880004; prog[4]  = 32'h00A63022; prog[5]  = 32'h1000FFFF;
    prog[6]  = 32'h08008000; prog[7]  = 32'h2108FFFF; prog[8]  = 32'hAFBF0010;
    prog[9]  = 32'h03E00008; prog[10] = 32'h012A4025; prog[11] = 32'h00000000;
    bw[0] = 32'hA0A1A2A3; bw[1] = 32'hB0B1B2B3; bw[2] = 32'hC0C1C2C3; bw[3] = 32'hD0D1D2D3;

    reset = 1'b1; address = '0; data_in = '0; access_size = '0; rw = 1'b0;
    enable = 1'b0; enable_fetch = 1'b0; stall = 1'b0; enable_decode = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_pc_fetch", pc_fetch, START);
    chk("rst_pc_decode", pc_decode, 32'h0);
    chk("rst_insn", insn, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(decode_valid), 32'h0);
    chk("rst_imm", 32'(imm_out), 32'h0);
    chk("rw_fetch", 32'(rw_fetch), 32'h1);
    chk("access_size_fetch", access_size_fetch, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) mem_write(START + 32'(4 * i), prog[i]);

    // Fetch stream with a 3-cycle stall on edges 5..7
    enable_fetch = 1'b1; enable_decode = 1'b1;
    exp_pc = START; exp_pcd = '0; exp_insn = '0; exp_fld = '0; exp_fdv = 1'b0; exp_dv = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      stall = (e >= 5 && e <= 7);
      @(posedge clock); #1;
      exp_dv  = exp_fdv;
      exp_fld = exp_insn;
      if (!stall) begin
        exp_pcd  = exp_pc;
        exp_insn = prog[(exp_pc - START) >> 2];
        exp_pc   = exp_pc + 32'd4;
        exp_fdv  = 1'b1;
      end
      chk($sformatf("pc_fetch_e%0d", e), pc_fetch, exp_pc);
      chk($sformatf("pc_decode_e%0d", e), pc_decode, exp_pcd);
      chk($sformatf("insn_e%0d", e), insn, exp_insn);
      chk($sformatf("valid_e%0d", e), 32'(decode_valid), 32'(exp_dv));
      if (e >= 2) begin
        chk($sformatf("opcode_e%0d", e), 32'(opcode_out), 32'(exp_fld[31:26]));
        chk($sformatf("rt_e%0d", e), 32'(rt_out), 32'(exp_fld[20:16]));
        chk($sformatf("func_e%0d", e), 32'(func_out), 32'(exp_fld[5:0]));
      end
      if (e == 2) begin
        chk("i0_opcode", 32'(opcode_out), 32'h09);
        chk("i0_rs", 32'(rs_out), 32'h1D);
        chk("i0_rt", 32'(rt_out), 32'h1D);
        chk("i0_imm", 32'(imm_out), 32'h3FFFFF8);
      end
      if (e == 3) begin
        chk("i1_opcode", 32'(opcode_out), 32'h00);
        chk("i1_rs", 32'(rs_out), 32'h04);
        chk("i1_rt", 32'(rt_out), 32'h05);
        chk("i1_rd", 32'(rd_out), 32'h02);
        chk("i1_sa", 32'(sa_out), 32'h00);
        chk("i1_func", 32'(func_out), 32'h20);
      end
      if (e == 4) begin
        chk("i2_opcode", 32'(opcode_out), 32'h03);
        chk("i2_imm", 32'(imm_out), 32'h0008010);
      end
      if (e == 8) chk("stall_fields_held", 32'(imm_out), 32'h0000004);
    end
    stall = 1'b0;
    enable_fetch = 1'b0; enable_decode = 1'b0;
    @(posedge clock); #1;
    chk("fetch_off_pc", pc_fetch, START);
    chk("fetch_off_valid", 32'(decode_valid), 32'h0);

    // 4-word burst write then burst read
    address = START + 32'h100; data_in = bw[0]; rw = 1'b0; access_size = 2'b01; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("wr_busy_%0d", i), 32'(busy), 32'h1);
      data_in = bw[i];
      @(posedge clock); #1;
    end
    chk("wr_busy_end", 32'(busy), 32'h0);
    address = START + 32'h100; rw = 1'b1; access_size = 2'b01; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_data_%0d", i), data_out, bw[i]);
      chk($sformatf("rd_busy_%0d", i), 32'(busy), (i < 3) ? 32'h1 : 32'h0);
      if (i < 3) begin
        @(posedge clock); #1;
      end
    end

    // Address wrap: START+DEPTH aliases START
    mem_write(START + 32'(DEPTH), 32'hCAFEF00D);
    mem_read(START);
    chk("wrap_read", data_out, 32'hCAFEF00D);

    // Byte order: unaligned read exposes the big-endian byte placement
    mem_write(START + 32'h204, 32'h00000000);
    mem_write(START + 32'h200, 32'h11223344);
    mem_read(START + 32'h200);
    chk("byte_order_word", data_out, 32'h11223344);
    mem_read(START + 32'h201);
    chk("byte_order_shift", data_out, 32'h22334400);

    // Reset during a 16-word read burst
    address = START; rw = 1'b1; access_size = 2'b11; enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("burst16_busy", 32'(busy), 32'h1);
    reset = 1'b1; #1;
    chk("burst16_rst_busy", 32'(busy), 32'h0);
    chk("burst16_rst_data", data_out, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset during fetch
    enable_fetch = 1'b1; enable_decode = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("fetch_run_pc", pc_fetch, START + 32'd12);
    reset = 1'b1; #1;
    chk("fetch_rst_pc", pc_fetch, START);
    chk("fetch_rst_pcd", pc_decode, 32'h0);
    chk("fetch_rst_valid", 32'(decode_valid), 32'h0);
    @(posedge clock); #1;
    enable_fetch = 1'b0; enable_decode = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

    // Memory contents survive reset
    mem_read(START + 32'h100);
    chk("kept_burst_word", data_out, bw[0]);
    mem_read(START);
    chk("kept_wrap_word", data_out, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
